load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sequences one data-memory access at a time between the execute stage and the byte-addressed, little-endian data memory.
- Memory side: combinational read (fetch_addr to fetched_data) and a synchronous write of 0..4 bytes (bytes_to_write, write_addr, write_data).
- Core side: valid/ready request and response handshakes.
- Decodes RV32 load/store widths, checks alignment, sign/zero-extends load data and flags faults.

Parameters:
ADDR_WIDTH, 32, byte-address width.
DATA_WIDTH, 32, data width; only 32 is supported (RV32).

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_is_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32 width code.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  DATA_WIDTH  store data (low bytes used).
resp_valid  output  1  response present.
resp_ready  input  1  core accepts response.
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and faults.
resp_misaligned  output  1  address not aligned to access size.
resp_illegal  output  1  unsupported funct3.
mem_fetch_addr  output  ADDR_WIDTH  memory read address.
mem_fetched_data  input  DATA_WIDTH  memory read data; byte at fetch address in [7:0].
mem_bytes_to_write  output  3  bytes to write; 0 = no write.
mem_write_addr  output  ADDR_WIDTH  memory write address.
mem_write_data  output  DATA_WIDTH  memory write data.

Behaviour:
- State machine IDLE -> ACCESS -> RESPOND -> IDLE.
- Request registers: addr_q, funct3_q, is_store_q, wdata_q. Response registers: rdata_q, mis_q, ill_q.
- Reset (rst high at posedge):
  - state = IDLE and all registers = 0.
  - While rst is high: req_ready = 0, resp_valid = 0, mem_bytes_to_write = 0.
  - Reset mid-ACCESS suppresses the write.
  - Reset mid-RESPOND drops the response.
- Funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
  - Sizes: byte = 1, half = 2, word = 4.
- Alignment:
  - Half requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Illegal takes priority: illegal sets ill_q only; mis_q stays 0.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture the request registers.
  - Legal and aligned: go to ACCESS.
  - Otherwise: go directly to RESPOND with rdata_q = 0 and the fault flag set. No memory access and no write is issued.
- ACCESS (exactly one cycle, req_ready = 0):
  - mem_fetch_addr = mem_write_addr = addr_q; mem_write_data = wdata_q.
  - Store: mem_bytes_to_write = size. Memory commits on the posedge ending this cycle. rdata_q is set to 0.
  - Load: mem_bytes_to_write = 0. rdata_q captures mem_fetched_data:
    - LB sign-extends [7:0]; LBU zero-extends [7:0].
    - LH sign-extends [15:0]; LHU zero-extends [15:0].
    - LW takes [31:0].
  - Then go to RESPOND.
- RESPOND:
  - resp_valid = 1; outputs come from rdata_q, mis_q, ill_q and are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE.
  - req_ready = 0, so a request arriving in this cycle is not accepted.
- Default drives: mem_bytes_to_write = 0 in every state except ACCESS-store. mem_fetch_addr and mem_write_addr always equal addr_q.
- Latency:
  - Request accepted at edge N: resp_valid is high in the cycle after edge N+1.
  - Faulting requests: resp_valid is high in the cycle after edge N.
  - Best-case throughput is one access per 3 cycles.
- Address arithmetic is ADDR_WIDTH-bit and is not checked against memory size; wrap-around is the memory's concern.
- resp_rdata, resp_misaligned and resp_illegal hold their last registered values outside RESPOND; only resp_valid qualifies them.

Test Plan:
- Reset is held 2 cycles with req_valid = 1 -> req_ready = 0, resp_valid = 0, mem_bytes_to_write = 0. The first request after rst falls is accepted.
- SW addr 0x100, wdata 0xDEADBEEF, then LW 0x100 -> the store's ACCESS cycle shows mem_bytes_to_write = 4, addr 0x100. The load returns resp_rdata = 0xDEADBEEF with no flags.
- Memory 0x200..0x203 = 80 FF 34 12. LB 0x200 -> 0xFFFFFF80; LBU 0x200 -> 0x00000080; LH 0x200 -> 0xFFFFFF80; LHU 0x202 -> 0x00001234.
- SH 0x201 -> resp_misaligned = 1, rdata 0, mem_bytes_to_write never nonzero, memory unchanged. LW 0x102 -> misaligned. funct3 = 011 load -> resp_illegal = 1, misaligned = 0.
- Backpressure: resp_ready held 0 for 5 cycles in RESPOND -> resp_valid and resp_rdata are stable, req_ready = 0, a pending req_valid is not accepted. It is accepted the cycle after resp_ready = 1.
- rst asserted during the ACCESS cycle of SB 0x300 -> no write (byte 0x300 unchanged), state returns to IDLE, no response is produced.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32 load/store sequencer between execute and a byte-addressed data memory.
// One access in flight: IDLE -> ACCESS -> RESPOND, faults skip ACCESS.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic [ADDR_WIDTH-1:0] mem_fetch_addr,
    input  logic [DATA_WIDTH-1:0] mem_fetched_data,
    output logic [2:0]            mem_bytes_to_write,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  is_store_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mis_q;
    logic                  ill_q;

    logic                  req_ill;
    logic                  req_mis;
    logic [2:0]            size_q;
    logic [DATA_WIDTH-1:0] load_ext;

    // Illegal wins over misaligned, so misalignment is only judged for legal codes.
    always_comb begin
        req_ill = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: req_ill = 1'b0;
            3'b100, 3'b101:         req_ill = req_is_store;
            default:                req_ill = 1'b1;
        endcase
        req_mis = 1'b0;
        if (!req_ill) begin
            case (req_funct3[1:0])
                2'b01:   req_mis = req_addr[0];
                2'b10:   req_mis = |req_addr[1:0];
                default: req_mis = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b01:   size_q = 3'd2;
            2'b10:   size_q = 3'd4;
            default: size_q = 3'd1;
        endcase
    end

    always_comb begin
        load_ext = mem_fetched_data;
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){mem_fetched_data[7]}},
                                 mem_fetched_data[7:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},
                                 mem_fetched_data[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){mem_fetched_data[15]}},
                                 mem_fetched_data[15:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}},
                                 mem_fetched_data[15:0]};
            default: load_ext = mem_fetched_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (req_ill || req_mis) ? RESPOND : ACCESS;
                end
            end
            ACCESS:  state_d = RESPOND;
            RESPOND: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                addr_q     <= req_addr;
                funct3_q   <= req_funct3;
                is_store_q <= req_is_store;
                wdata_q    <= req_wdata;
                mis_q      <= req_mis;
                ill_q      <= req_ill;
                if (req_ill || req_mis) rdata_q <= '0;
            end
            if (state_q == ACCESS) begin
                rdata_q <= is_store_q ? '0 : load_ext;
            end
        end
    end

    // Handshake and write strobes are gated by rst so a reset mid-access is clean.
    always_comb begin
        req_ready          = 1'b0;
        resp_valid         = 1'b0;
        mem_bytes_to_write = 3'd0;
        if (!rst) begin
            req_ready  = (state_q == IDLE);
            resp_valid = (state_q == RESPOND);
            if (state_q == ACCESS && is_store_q) mem_bytes_to_write = size_q;
        end
    end

    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign resp_illegal    = ill_q;
    assign mem_fetch_addr  = addr_q;
    assign mem_write_addr  = addr_q;
    assign mem_write_data  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic [31:0] mem_fetch_addr;
    logic [31:0] mem_fetched_data;
    logic [2:0]  mem_bytes_to_write;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];
    logic [9:0] fa;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .resp_illegal(resp_illegal),
        .mem_fetch_addr(mem_fetch_addr), .mem_fetched_data(mem_fetched_data),
        .mem_bytes_to_write(mem_bytes_to_write),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fa = mem_fetch_addr[9:0];
    assign mem_fetched_data = {mem[fa+10'd3], mem[fa+10'd2],
                               mem[fa+10'd1], mem[fa]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i < int'(mem_bytes_to_write))
                mem[mem_write_addr[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request to completion; lat = 99 flags a timeout.
    task automatic transact(input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic mis,
                            output logic ill, output int lat,
                            output logic [2:0] wb, output logic [31:0] wa);
        int guard;
        req_valid = 1'b1;
        req_is_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            step();
            guard++;
        end
        step();
        req_valid = 1'b0;
        wb = 3'd0;
        wa = 32'hFFFF_FFFF;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            if (mem_bytes_to_write != 3'd0) begin
                wb = mem_bytes_to_write;
                wa = mem_write_addr;
            end
            step();
            lat++;
        end
        if (!resp_valid || guard >= 20) lat = 99;
        if (mem_bytes_to_write != 3'd0) wb = mem_bytes_to_write;
        rd = resp_rdata;
        mis = resp_misaligned;
        ill = resp_illegal;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        req_is_store = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h100;
        req_wdata = 32'hDEADBEEF;
        resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b0 ||
                mem_bytes_to_write !== 3'd0) begin
                errors++;
                $display("FAIL rst_hold cyc %0d rdy=%b vld=%b bw=%0d need 0 0 0",
                         i, req_ready, resp_valid, mem_bytes_to_write);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
            resp_misaligned !== 1'b0 || resp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL rst_state rdy=%b vld=%b rd=%h m=%b i=%b need 1 0 0 0 0",
                     req_ready, resp_valid, resp_rdata,
                     resp_misaligned, resp_illegal);
        end
        step();
        checks++;
        if (mem_bytes_to_write !== 3'd4 || mem_write_addr !== 32'h100 ||
            mem_write_data !== 32'hDEADBEEF || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_sw_access bw=%0d wa=%h wd=%h rdy=%b need 4 100 deadbeef 0",
                     mem_bytes_to_write, mem_write_addr, mem_write_data, req_ready);
        end
        req_valid = 1'b0;
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 ||
            resp_misaligned !== 1'b0 || resp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL first_sw_resp vld=%b rd=%h m=%b i=%b need 1 0 0 0",
                     resp_valid, resp_rdata, resp_misaligned, resp_illegal);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if ({mem[259], mem[258], mem[257], mem[256]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem got %h need deadbeef",
                     {mem[259], mem[258], mem[257], mem[256]});
        end
    endtask

    task automatic test_load_word();
        logic [31:0] rd, wa;
        logic mis, ill;
        logic [2:0] wb;
        int lat;
        transact(1'b0, 3'b010, 32'h100, 32'h0, rd, mis, ill, lat, wb, wa);
        checks++;
        if (rd !== 32'hDEADBEEF || mis !== 1'b0 || ill !== 1'b0 ||
            lat !== 1 || wb !== 3'd0) begin
            errors++;
            $display("FAIL lw_100 rd=%h m=%b i=%b lat=%0d bw=%0d need deadbeef 0 0 1 0",
                     rd, mis, ill, lat, wb);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
        logic [31:0] ad [6] = '{32'h200, 32'h200, 32'h200, 32'h202, 32'h202, 32'h200};
        logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80,
                                32'h00001234, 32'h00001234, 32'h1234FF80};
        logic [31:0] rd, wa;
        logic mis, ill;
        logic [2:0] wb;
        int lat;
        transact(1'b1, 3'b010, 32'h200, 32'h1234FF80, rd, mis, ill, lat, wb, wa);
        checks++;
        if (wb !== 3'd4 || wa !== 32'h200 || lat !== 1) begin
            errors++;
            $display("FAIL sw_200 bw=%0d wa=%h lat=%0d need 4 200 1", wb, wa, lat);
        end
        for (int i = 0; i < 6; i++) begin
            transact(1'b0, f3[i], ad[i], 32'h0, rd, mis, ill, lat, wb, wa);
            checks++;
            if (rd !== ex[i] || mis !== 1'b0 || ill !== 1'b0 || lat !== 1) begin
                errors++;
                $display("FAIL load_ext f3=%b a=%h rd=%h m=%b i=%b lat=%0d need %h 0 0 1",
                         f3[i], ad[i], rd, mis, ill, lat, ex[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic        st [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [5] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b100};
        logic [31:0] ad [5] = '{32'h201, 32'h102, 32'h100, 32'h103, 32'h200};
        logic        em [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ei [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] rd, wa;
        logic mis, ill;
        logic [2:0] wb;
        int lat;
        for (int i = 0; i < 5; i++) begin
            transact(st[i], f3[i], ad[i], 32'hA5A5A5A5, rd, mis, ill, lat, wb, wa);
            checks++;
            if (rd !== 32'h0 || mis !== em[i] || ill !== ei[i] ||
                lat !== 0 || wb !== 3'd0) begin
                errors++;
                $display("FAIL fault %0d rd=%h m=%b i=%b lat=%0d bw=%0d need 0 %b %b 0 0",
                         i, rd, mis, ill, lat, wb, em[i], ei[i]);
            end
        end
        checks++;
        if ({mem[515], mem[514], mem[513], mem[512]} !== 32'h1234FF80) begin
            errors++;
            $display("FAIL fault_mem got %h need 1234ff80",
                     {mem[515], mem[514], mem[513], mem[512]});
        end
    endtask

    task automatic test_backpressure();
        int bad;
        req_valid = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h100;
        req_wdata = 32'h0;
        step();
        req_funct3 = 3'b100;
        req_addr = 32'h200;
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF ||
                req_ready !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold bad_cycles=%0d need 0 (vld=%b rd=%h rdy=%b)",
                     bad, resp_valid, resp_rdata, req_ready);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release rdy=%b vld=%b need 1 0", req_ready, resp_valid);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept rdy=%b vld=%b need 0 0", req_ready, resp_valid);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000080) begin
            errors++;
            $display("FAIL bp_second vld=%b rd=%h need 1 00000080",
                     resp_valid, resp_rdata);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_access();
        logic [31:0] rd, wa;
        logic mis, ill;
        logic [2:0] wb;
        int lat;
        int seen;
        transact(1'b1, 3'b010, 32'h300, 32'h000000AA, rd, mis, ill, lat, wb, wa);
        req_valid = 1'b1;
        req_is_store = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h300;
        req_wdata = 32'h00000055;
        step();
        req_valid = 1'b0;
        checks++;
        if (mem_bytes_to_write !== 3'd1) begin
            errors++;
            $display("FAIL sb_access bw=%0d need 1", mem_bytes_to_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_bytes_to_write !== 3'd0) begin
            errors++;
            $display("FAIL sb_rst_gate bw=%0d need 0", mem_bytes_to_write);
        end
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (resp_valid !== 1'b0) seen++;
            step();
        end
        checks++;
        if (seen != 0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sb_rst_idle resp_cycles=%0d rdy=%b rd=%h need 0 1 0",
                     seen, req_ready, resp_rdata);
        end
        checks++;
        if (mem[768] !== 8'hAA) begin
            errors++;
            $display("FAIL sb_rst_mem got %h need aa", mem[768]);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_faults();
        test_backpressure();
        test_reset_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
